ga_mv_classifier: RTL and testbench



---
 rtl/ga_mv_classifier.sv | 204 ++++++++++++++++++++
 tb/tb_ga_mv_classifier.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ga_mv_classifier.sv
// ga_mv_classifier: sequential grade/shape classifier for 32-blade 5D CGA multivectors.
// Optional CGA point/sphere flags are built when GA_CLASSIFY_CGA_EN is defined.
module ga_mv_classifier #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [32*WIDTH-1:0]   mv_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [2:0]            grade_o,
    output logic [5:0]            grade_mask_o,
    output logic [WIDTH-1:0]      max_mag_o,
    output logic                  is_zero_o,
    output logic                  is_scalar_o,
    output logic                  is_vector_o,
    output logic                  is_bivector_o,
    output logic                  is_homog_o
`ifdef GA_CLASSIFY_CGA_EN
    ,
    output logic                  cga_point_o,
    output logic                  cga_sphere_o
`endif
);

    localparam int unsigned MV_W     = 32 * WIDTH;
    localparam int unsigned SHIFT    = LANES * WIDTH;
    localparam int unsigned LAST_IDX = 32 - LANES;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [MV_W-1:0]    mv_q, mv_d;
    logic [4:0]         idx_q, idx_d;
    logic [WIDTH-1:0]   max_q [6];
    logic [WIDTH-1:0]   max_d [6];
    logic [5:0]         mask_q, mask_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [2:0]         grade_q, grade_d;
    logic [5:0]         gmask_q, gmask_d;
    logic [WIDTH-1:0]   max_mag_q, max_mag_d;
    logic [4:0]         flags_q, flags_d;

    logic [4:0]         blade_c;
    logic [2:0]         lane_grade_c;
    logic [WIDTH-1:0]   coef_c;
    logic [WIDTH-1:0]   mag_c;
    logic [WIDTH-1:0]   best_c;
    logic [2:0]         best_g_c;

`ifdef GA_CLASSIFY_CGA_EN
    logic scalar_nz_q, scalar_nz_d;
    logic e4_nz_q, e4_nz_d;
    logic cga_point_q, cga_point_d;
    logic cga_sphere_q, cga_sphere_d;
`endif

    function automatic logic [2:0] blade_grade(input logic [4:0] b);
        if (b == 5'd0)       return 3'd0;
        else if (b <= 5'd5)  return 3'd1;
        else if (b <= 5'd15) return 3'd2;
        else if (b <= 5'd25) return 3'd3;
        else if (b <= 5'd30) return 3'd4;
        else                 return 3'd5;
    endfunction

    // Next-state: lanes read the top of mv_q, which shifts up by LANES blades per cycle.
    always_comb begin
        state_d      = state_q;
        mv_d         = mv_q;
        idx_d        = idx_q;
        max_d        = max_q;
        mask_d       = mask_q;
        grade_d      = grade_q;
        gmask_d      = gmask_q;
        max_mag_d    = max_mag_q;
        flags_d      = flags_q;
        blade_c      = '0;
        lane_grade_c = '0;
        coef_c       = '0;
        mag_c        = '0;
        best_c       = '0;
        best_g_c     = '0;
`ifdef GA_CLASSIFY_CGA_EN
        scalar_nz_d  = scalar_nz_q;
        e4_nz_d      = e4_nz_q;
        cga_point_d  = cga_point_q;
        cga_sphere_d = cga_sphere_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    mv_d    = mv_i;
                    idx_d   = '0;
                    mask_d  = '0;
                    for (int unsigned g = 0; g < 6; g++) max_d[g] = '0;
                    state_d = S_SCAN;
`ifdef GA_CLASSIFY_CGA_EN
                    scalar_nz_d = |mv_i[MV_W-1 -: WIDTH];
                    e4_nz_d     = |mv_i[MV_W-1-4*WIDTH -: WIDTH];
`endif
                end
            end
            S_SCAN: begin
                // Sequential lane loop reduces same-grade lanes before the register update.
                for (int unsigned l = 0; l < LANES; l++) begin
                    blade_c      = idx_q + 5'(l);
                    lane_grade_c = blade_grade(blade_c);
                    coef_c       = mv_q[MV_W-1-l*WIDTH -: WIDTH];
                    mag_c        = coef_c[WIDTH-1] ? WIDTH'(-coef_c) : coef_c;
                    if (mag_c > max_d[lane_grade_c]) max_d[lane_grade_c] = mag_c;
                    if (mag_c != '0) mask_d[lane_grade_c] = 1'b1;
                end
                mv_d  = mv_q << SHIFT;
                idx_d = idx_q + 5'(LANES);
                if (idx_q == 5'(LAST_IDX)) begin
                    best_c   = max_d[0];
                    best_g_c = 3'd0;
                    for (int unsigned g = 1; g < 6; g++) begin
                        if (max_d[g] > best_c) begin
                            best_c   = max_d[g];
                            best_g_c = 3'(g);
                        end
                    end
                    grade_d   = best_g_c;
                    gmask_d   = mask_d;
                    max_mag_d = best_c;
                    flags_d   = {mask_d == 6'b000000,
                                 mask_d[5:1] == 5'b00000,
                                 mask_d == 6'b000010,
                                 mask_d == 6'b000100,
                                 $countones(mask_d) == 1};
`ifdef GA_CLASSIFY_CGA_EN
                    cga_point_d  = !scalar_nz_q && e4_nz_q && (mask_d[5:2] == 4'b0000);
                    cga_sphere_d = (mask_d == 6'b010000);
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            mv_q        <= '0;
            idx_q       <= '0;
            for (int unsigned g = 0; g < 6; g++) max_q[g] <= '0;
            mask_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            grade_q     <= '0;
            gmask_q     <= '0;
            max_mag_q   <= '0;
            flags_q     <= '0;
`ifdef GA_CLASSIFY_CGA_EN
            scalar_nz_q  <= 1'b0;
            e4_nz_q      <= 1'b0;
            cga_point_q  <= 1'b0;
            cga_sphere_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mv_q        <= mv_d;
            idx_q       <= idx_d;
            for (int unsigned g = 0; g < 6; g++) max_q[g] <= max_d[g];
            mask_q      <= mask_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            grade_q     <= grade_d;
            gmask_q     <= gmask_d;
            max_mag_q   <= max_mag_d;
            flags_q     <= flags_d;
`ifdef GA_CLASSIFY_CGA_EN
            scalar_nz_q  <= scalar_nz_d;
            e4_nz_q      <= e4_nz_d;
            cga_point_q  <= cga_point_d;
            cga_sphere_q <= cga_sphere_d;
`endif
        end
    end

    assign in_ready_o   = in_ready_q;
    assign out_valid_o  = out_valid_q;
    assign grade_o      = grade_q;
    assign grade_mask_o = gmask_q;
    assign max_mag_o    = max_mag_q;
    assign {is_zero_o, is_scalar_o, is_vector_o, is_bivector_o, is_homog_o} = flags_q;
`ifdef GA_CLASSIFY_CGA_EN
    assign cga_point_o  = cga_point_q;
    assign cga_sphere_o = cga_sphere_q;
`endif

endmodule

// File: tb/tb_ga_mv_classifier.sv
// Testbench for ga_mv_classifier: three instances (LANES 4, 1, 32) checked against a blade-level model.
module tb_ga_mv_classifier;

    localparam int unsigned W    = 16;
    localparam int unsigned MVW  = 32 * W;
    localparam int unsigned NDUT = 3;

    typedef struct packed {
        logic [2:0]   grade;
        logic [5:0]   mask;
        logic [W-1:0] maxm;
        logic [4:0]   flags;
        logic         point;
        logic         sphere;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic           in_valid  [NDUT];
    logic           in_ready  [NDUT];
    logic           out_valid [NDUT];
    logic           out_ready [NDUT];
    logic [MVW-1:0] mv        [NDUT];
    logic [2:0]     grade     [NDUT];
    logic [5:0]     gmask     [NDUT];
    logic [W-1:0]   maxm      [NDUT];
    logic           is_zero   [NDUT];
    logic           is_scalar [NDUT];
    logic           is_vector [NDUT];
    logic           is_biv    [NDUT];
    logic           is_homog  [NDUT];
    logic           cga_point [NDUT];
    logic           cga_sphere[NDUT];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        localparam int unsigned L = (k == 0) ? 4 : ((k == 1) ? 1 : 32);
        ga_mv_classifier #(.WIDTH(W), .LANES(L)) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .in_valid_i   (in_valid[k]),
            .in_ready_o   (in_ready[k]),
            .mv_i         (mv[k]),
            .out_valid_o  (out_valid[k]),
            .out_ready_i  (out_ready[k]),
            .grade_o      (grade[k]),
            .grade_mask_o (gmask[k]),
            .max_mag_o    (maxm[k]),
            .is_zero_o    (is_zero[k]),
            .is_scalar_o  (is_scalar[k]),
            .is_vector_o  (is_vector[k]),
            .is_bivector_o(is_biv[k]),
            .is_homog_o   (is_homog[k])
`ifdef GA_CLASSIFY_CGA_EN
            ,
            .cga_point_o  (cga_point[k]),
            .cga_sphere_o (cga_sphere[k])
`endif
        );
`ifndef GA_CLASSIFY_CGA_EN
        assign cga_point[k]  = 1'b0;
        assign cga_sphere[k] = 1'b0;
`endif
    end

    function automatic int lanes_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 1 : 32);
    endfunction

    function automatic int grade_of(input int b);
        if (b == 0) return 0;
        if (b < 6)  return 1;
        if (b < 16) return 2;
        if (b < 26) return 3;
        if (b < 31) return 4;
        return 5;
    endfunction

    function automatic logic [MVW-1:0] set_blade(input logic [MVW-1:0] v, input int b, input logic [W-1:0] c);
        logic [MVW-1:0] r;
        r = v;
        r[MVW-1-b*W -: W] = c;
        return r;
    endfunction

    // Reference: per-grade max |coefficient| over the blades, then pick the largest (lowest grade on ties).
    function automatic exp_t model(input logic [MVW-1:0] v);
        exp_t e;
        int mx[6];
        int m, g, best, bg;
        logic signed [W-1:0] c;
        logic signed [W-1:0] c0, c4;
        for (int i = 0; i < 6; i++) mx[i] = 0;
        e = '0;
        for (int b = 0; b < 32; b++) begin
            c = v[MVW-1-b*W -: W];
            m = int'(c);
            if (m < 0) m = -m;
            g = grade_of(b);
            if (m > mx[g]) mx[g] = m;
            if (m != 0) e.mask[g] = 1'b1;
        end
        best = mx[0];
        bg = 0;
        for (int i = 1; i < 6; i++) if (mx[i] > best) begin best = mx[i]; bg = i; end
        e.grade = 3'(bg);
        e.maxm  = W'(best);
        e.flags = {e.mask == 6'd0, e.mask[5:1] == 5'd0, e.mask == 6'b000010,
                   e.mask == 6'b000100, $countones(e.mask) == 1};
        c0 = v[MVW-1 -: W];
        c4 = v[MVW-1-4*W -: W];
        e.point  = (c0 == 0) && (c4 != 0) && (e.mask[5:2] == 4'd0);
        e.sphere = (e.mask == 6'b010000);
        return e;
    endfunction

    function automatic logic [MVW-1:0] rand_mv(input int mode);
        logic [MVW-1:0] v;
        logic [W-1:0] c;
        int gsel;
        v = '0;
        gsel = $urandom_range(5);
        for (int b = 0; b < 32; b++) begin
            c = W'($urandom);
            case ($urandom_range(5))
                0: c = 16'h8000;
                1, 2: c = '0;
                3: c = W'($urandom_range(7));
                default: ;
            endcase
            if (mode == 1 && grade_of(b) != gsel) c = '0;
            if (mode == 2 && b != 0 && $urandom_range(3) != 0) c = '0;
            v = set_blade(v, b, c);
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input int k, input exp_t e, input string tag);
        check($sformatf("%s_grade_u%0d", tag, k), 64'(grade[k]), 64'(e.grade));
        check($sformatf("%s_mask_u%0d", tag, k), 64'(gmask[k]), 64'(e.mask));
        check($sformatf("%s_max_u%0d", tag, k), 64'(maxm[k]), 64'(e.maxm));
        check($sformatf("%s_flags_u%0d", tag, k),
              64'({is_zero[k], is_scalar[k], is_vector[k], is_biv[k], is_homog[k]}), 64'(e.flags));
`ifdef GA_CLASSIFY_CGA_EN
        check($sformatf("%s_cga_u%0d", tag, k), 64'({cga_point[k], cga_sphere[k]}),
              64'({e.point, e.sphere}));
`endif
    endtask

    task automatic run_job(input int k, input logic [MVW-1:0] v, input int stall);
        exp_t e;
        int lat;
        e = model(v);
        lat = 0;
        while (!in_ready[k] && lat < 80) begin @(posedge clk); #1; lat++; end
        check($sformatf("idle_ready_u%0d", k), 64'(in_ready[k]), 64'd1);
        in_valid[k]  = 1'b1;
        mv[k]        = v;
        out_ready[k] = 1'b0;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        mv[k]       = {16{$urandom}};
        check($sformatf("busy_ready_u%0d", k), 64'(in_ready[k]), 64'd0);
        lat = 0;
        while (!out_valid[k] && lat < 64) begin @(posedge clk); #1; lat++; end
        check($sformatf("latency_u%0d", k), 64'(lat), 64'(32 / lanes_of(k)));
        check_outputs(k, e, "done");
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check($sformatf("stall_valid_u%0d", k), 64'({out_valid[k], in_ready[k]}), 64'b10);
            check_outputs(k, e, "stall");
        end
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        check($sformatf("release_u%0d", k), 64'({out_valid[k], in_ready[k]}), 64'b01);
        check_outputs(k, e, "hold");
    endtask

    initial begin
        logic [MVW-1:0] v;
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b0; mv[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst_hs_u%0d", k), 64'({in_ready[k], out_valid[k]}), 64'b10);
            check_outputs(k, '0, "rst");
        end
        rst = 1'b0;

        // Pure vector e3 = -5
        v = set_blade('0, 3, 16'hFFFB);
        run_job(0, v, 0);
        check("vec_grade", 64'(grade[0]), 64'd1);
        check("vec_mask", 64'(gmask[0]), 64'b000010);
        check("vec_max", 64'(maxm[0]), 64'd5);
        check("vec_flags", 64'({is_vector[0], is_homog[0]}), 64'b11);

        // Most negative magnitude beats 0x7FFF
        v = set_blade(set_blade('0, 0, 16'h8000), 6, 16'h7FFF);
        run_job(0, v, 1);
        check("neg_max", 64'(maxm[0]), 64'h8000);
        check("neg_grade", 64'(grade[0]), 64'd0);

        // Tie resolves to the lower grade
        v = set_blade(set_blade('0, 0, 16'd7), 15, 16'hFFF9);
        run_job(0, v, 0);
        check("tie_grade", 64'(grade[0]), 64'd0);
        check("tie_max", 64'(maxm[0]), 64'd7);

        // Mixed grades with back-pressure
        v = set_blade(set_blade(set_blade('0, 16, 16'd100), 26, 16'd200), 31, 16'd50);
        run_job(0, v, 5);
        check("mix_grade", 64'(grade[0]), 64'd4);
        check("mix_mask", 64'(gmask[0]), 64'b111000);
        check("mix_max", 64'(maxm[0]), 64'd200);

        // Abort in the third scan cycle
        in_valid[0] = 1'b1;
        mv[0] = {16{$urandom}};
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_hs", 64'({in_ready[0], out_valid[0]}), 64'b10);
        check_outputs(0, '0, "abort");
        v = set_blade('0, 30, 16'd9);
        run_job(0, v, 0);
        check("post_abort_grade", 64'(grade[0]), 64'd4);
        check("post_abort_mask", 64'(gmask[0]), 64'b010000);

        // Randomised jobs on the 4-lane instance
        for (int i = 0; i < 12; i++) run_job(0, rand_mv(i % 3), i % 3);

        // Lane sweep: 1 lane and 32 lanes
        run_job(1, '0, 0);
        check("l1_zero", 64'({is_zero[1], is_scalar[1]}), 64'b11);
        run_job(1, rand_mv(0), 1);
        run_job(1, rand_mv(1), 0);
        run_job(2, '0, 0);
        check("l32_zero", 64'({is_zero[2], is_scalar[2], grade[2]}), 64'b11000);
        run_job(2, rand_mv(0), 2);
        run_job(2, rand_mv(2), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
